play_ctrl: RTL
==============

PLAY_CTRL -- requirements
Module: play_ctrl

Interface
REQ-001 SHALL have parameter MS_DIV, default 1000, meaning CLK_1MHZ cycles per 1 ms tick.
REQ-002 SHALL have parameter DEB_CYC, default 20000, meaning consecutive stable cycles required to accept a key change.
REQ-003 SHALL have parameter PLAY_MS, default 45000, meaning automatic play timeout in ms (max 65535).
REQ-004 SHALL have port CLK_1MHZ, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port ALARM, input, 1 bit: asynchronous alarm-match level; a rising edge requests alarm play.
REQ-007 SHALL have port KEY_T, input, 1 bit: raw mechanical test button, active-low, bouncing.
REQ-008 SHALL have port A, output, 1 bit: alarm-play enable to the piezo song player.
REQ-009 SHALL have port T, output, 1 bit: test-play enable to the piezo song player.
REQ-010 SHALL have port BUSY, output, 1 bit: high in any state other than IDLE.

Function
REQ-011 SHALL pass ALARM and KEY_T each through a 2-FF synchronizer.
REQ-012 SHALL detect an ALARM rising edge from the synchronized level, giving a 1-cycle pulse; an ALARM edge changes A exactly 3 cycles after the first edge sampling ALARM high.
REQ-013 SHALL debounce KEY_T as follows: a difference counter counts cycles where the synchronized level differs from the debounced level and clears when they are equal; at DEB_CYC the debounced level flips.
REQ-014 SHALL generate a 1-cycle press pulse on a debounced 1->0 flip; a release generates no event; A/T change DEB_CYC+3 cycles after the first edge sampling the new raw level.
REQ-015 SHALL implement states IDLE, PLAY_A, PLAY_T, GAP; A=1 only in PLAY_A, T=1 only in PLAY_T; outputs are registered.
REQ-016 SHALL transition IDLE as follows: alarm pulse -> PLAY_A; press -> PLAY_T; simultaneous alarm and press -> PLAY_A (alarm priority).
REQ-017 SHALL transition PLAY_A as follows: press -> IDLE; timeout -> IDLE; alarm pulse ignored.
REQ-018 SHALL transition PLAY_T as follows: press -> IDLE; timeout -> IDLE; alarm pulse -> GAP (alarm preempts test, with priority over a simultaneous press).
REQ-019 SHALL hold GAP for exactly 1 cycle with A=T=0, forcing the downstream song to restart at its first note, then go to PLAY_A.
REQ-020 SHALL implement the timeout as follows: the ms prescaler (0..MS_DIV-1) and a 16-bit ms counter clear on every entry to PLAY_A/PLAY_T; timeout fires when the ms counter reaches PLAY_MS, i.e. exactly PLAY_MS*MS_DIV cycles after entry.
REQ-021 SHALL stop the prescaler and ms counter and hold them at 0 in IDLE/GAP; neither wraps.
REQ-022 SHALL give a press coinciding with timeout the same result as timeout, i.e. IDLE; a press arriving in IDLE is never queued.

Reset
REQ-023 SHALL, on RESET=1 at a clock edge, force: state IDLE, A=0, T=0, BUSY=0, synchronizers to idle levels (ALARM 0, KEY_T 1), debounced key 1, all counters 0.
REQ-024 SHALL generate no alarm or press event in the first cycle after reset release, even if ALARM is high or KEY_T is low.
REQ-025 SHALL abort play on reset mid-operation, with outputs low at the reset edge.

Structure
REQ-026 SHALL place the state encoding enum and the default constants (MS_DIV, DEB_CYC, PLAY_MS) in shared package play_ctrl_pkg.
REQ-027 SHALL implement synchronizer, debounce counter and press-pulse generation in one sub-module, key_debounce, instantiated once for KEY_T.

Verification (sim params MS_DIV=10, DEB_CYC=8, PLAY_MS=5)
REQ-028 SHALL verify: reset, then ALARM 0->1 -> A=1 exactly 3 cycles later; A falls exactly 50 cycles after rising; BUSY tracks A.
REQ-029 SHALL verify: KEY_T low with bounces shorter than 8 cycles, then stable low -> T=1 exactly 11 cycles after the stable low begins; bounces produce no event.
REQ-030 SHALL verify: in PLAY_T, an ALARM edge -> T falls, one cycle with A=T=0, then A=1; the timeout counter restarts (A lasts 50 cycles).
REQ-031 SHALL verify: in PLAY_A, a second debounced press -> A=0 and IDLE; a further press -> T=1.
REQ-032 SHALL verify: alarm pulse and press in the same cycle from IDLE -> A=1, T=0.
REQ-033 SHALL verify: RESET asserted during PLAY_A at cycle 20 -> A=0 at that edge; with ALARM held high after release, A stays 0.

Source files
------------

// File: rtl/play_ctrl_pkg.sv
// Shared state encoding, default timing constants and a counter-width helper
// for the alarm/test play controller.
package play_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLAY_A = 2'd1,
        ST_PLAY_T = 2'd2,
        ST_GAP    = 2'd3
    } state_e;

    localparam int unsigned MS_DIV_DEF  = 1000;
    localparam int unsigned DEB_CYC_DEF = 20000;
    localparam int unsigned PLAY_MS_DEF = 45000;
    localparam int unsigned MS_CNT_W    = 16;

    // Width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/play_ctrl_key_debounce.sv
// Test-button conditioning: 2-FF synchronizer, stability counter and a
// one-cycle press pulse on each debounced high-to-low flip.
module key_debounce
    import play_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYC = DEB_CYC_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_i,
    output logic press_o
);

    localparam int unsigned CW = cnt_width(DEB_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          deb_q;
    logic          deb_d;
    logic          deb_prev_q;
    logic          press_q;

    // Any sample matching the accepted level restarts the stability window.
    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        if (sync2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            deb_d = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            cnt_q      <= '0;
            deb_q      <= 1'b1;
            deb_prev_q <= 1'b1;
            press_q    <= 1'b0;
        end else begin
            sync1_q    <= key_i;
            sync2_q    <= sync1_q;
            cnt_q      <= cnt_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            press_q    <= deb_prev_q & ~deb_q;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/play_ctrl.sv
// Piezo play controller: arbitrates alarm play against test-button play,
// with a millisecond play timeout and a one-cycle restart gap on preemption.
module play_ctrl
    import play_ctrl_pkg::*;
#(
    parameter int unsigned MS_DIV  = MS_DIV_DEF,
    parameter int unsigned DEB_CYC = DEB_CYC_DEF,
    parameter int unsigned PLAY_MS = PLAY_MS_DEF
) (
    input  logic CLK_1MHZ,
    input  logic RESET,
    input  logic ALARM,
    input  logic KEY_T,
    output logic A,
    output logic T,
    output logic BUSY
);

    localparam int unsigned PW = cnt_width(MS_DIV);
    localparam logic [PW-1:0]       PRE_LAST = PW'(MS_DIV - 1);
    localparam logic [MS_CNT_W-1:0] MS_LAST  = MS_CNT_W'(PLAY_MS - 1);

    logic                alm_s1_q;
    logic                alm_s2_q;
    logic                alm_prev_q;
    logic [2:0]          alm_vld_q;
    logic                alm_rise;
    logic                alm_pls_q;
    logic                press;
    state_e              state_q;
    state_e              state_d;
    logic [PW-1:0]       pre_q;
    logic [MS_CNT_W-1:0] ms_q;
    logic                counting;
    logic                timeout;
    logic                a_q;
    logic                t_q;
    logic                busy_q;

    key_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_key_debounce (
        .clk_i   (CLK_1MHZ),
        .rst_i   (RESET),
        .key_i   (KEY_T),
        .press_o (press)
    );

    // The edge detector is armed only once the previous-sample register holds
    // a real input sample, so a level already high at reset exit is no edge.
    assign alm_rise = alm_vld_q[2] & alm_s2_q & ~alm_prev_q;

    always_ff @(posedge CLK_1MHZ) begin
        if (RESET) begin
            alm_s1_q   <= 1'b0;
            alm_s2_q   <= 1'b0;
            alm_prev_q <= 1'b0;
            alm_vld_q  <= '0;
            alm_pls_q  <= 1'b0;
        end else begin
            alm_s1_q   <= ALARM;
            alm_s2_q   <= alm_s1_q;
            alm_prev_q <= alm_s2_q;
            alm_vld_q  <= {alm_vld_q[1:0], 1'b1};
            alm_pls_q  <= alm_rise;
        end
    end

    assign timeout = (pre_q == PRE_LAST) && (ms_q == MS_LAST);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (alm_pls_q) begin
                    state_d = ST_PLAY_A;
                end else if (press) begin
                    state_d = ST_PLAY_T;
                end
            end
            ST_PLAY_A: begin
                if (press || timeout) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PLAY_T: begin
                if (alm_pls_q) begin
                    state_d = ST_GAP;
                end else if (press || timeout) begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                state_d = ST_PLAY_A;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Counters run only while staying in a play state; any entry starts at 0.
    assign counting = ((state_q == ST_PLAY_A) || (state_q == ST_PLAY_T))
                      && (state_d == state_q);

    always_ff @(posedge CLK_1MHZ) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            pre_q   <= '0;
            ms_q    <= '0;
            a_q     <= 1'b0;
            t_q     <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= (state_d == ST_PLAY_A);
            t_q     <= (state_d == ST_PLAY_T);
            busy_q  <= (state_d != ST_IDLE);
            if (!counting) begin
                pre_q <= '0;
                ms_q  <= '0;
            end else if (pre_q == PRE_LAST) begin
                pre_q <= '0;
                ms_q  <= ms_q + 1'b1;
            end else begin
                pre_q <= pre_q + 1'b1;
            end
        end
    end

    assign A    = a_q;
    assign T    = t_q;
    assign BUSY = busy_q;

endmodule
